// File: rtl/wishbone_dev_pipelined.sv
// wishbone_dev_pipelined
//
// Wishbone B4 pipelined-mode device adapter. Bus requests are queued in an
// in-order command FIFO and presented one at a time to a local device through
// a simple request/ack/err handshake. Each queued request produces exactly one
// registered ack_o or err_o. A head request that waits TIMEOUT cycles without
// a device response is terminated with err_o.
//
// Ports
//   clk_i, rst_i        clock (rising edge) and synchronous active-high reset
//   cyc_i, stb_i        bus cycle / strobe; cyc_i low flushes everything queued
//   we_i, adr_i, dat_i, sel_i
//                       request attributes captured when the request is accepted
//   dat_o               read data, valid with ack_o
//   ack_o, err_o        one-cycle termination per accepted request
//   stall_o             FIFO full, request not accepted
//   request             FIFO head valid
//   write_en, address, write_data, byte_en
//                       head request attributes, stable until the head is popped
//   read_data           device read data, captured on an ack of a read
//   ack, err            device completes / fails the head request

module wishbone_dev_pipelined #(
  parameter int ADR_WIDTH = 8,
  parameter int DAT_WIDTH = 8,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0] sel_i,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 stall_o,
  output logic                 request,
  output logic                 write_en,
  output logic [ADR_WIDTH-1:0] address,
  output logic [DAT_WIDTH-1:0] write_data,
  output logic [SEL_WIDTH-1:0] byte_en,
  input  logic [DAT_WIDTH-1:0] read_data,
  input  logic                 ack,
  input  logic                 err
);

  localparam int PTR_W = $clog2(DEPTH);
  // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
  // declarations stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit               TMO_EN    = (TIMEOUT > 0);

  typedef struct packed {
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0] sel;
  } entry_t;

  entry_t           fifo_mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] tmo_cnt;

  logic full;
  logic push;
  logic pop;
  logic pop_err;
  logic waiting;
  logic timeout_hit;

  // Bus side: full alone decides stall, so a pop in the same cycle never
  // opens a slot for a push.
  assign full    = (count == FULL_CNT);
  assign stall_o = full;
  assign push    = cyc_i && stb_i && !full;

  // Device side: the head entry drives the device directly.
  assign head       = fifo_mem[rd_ptr];
  assign request    = (count != '0);
  assign write_en   = head.we;
  assign address    = head.adr;
  assign write_data = head.dat;
  assign byte_en    = head.sel;

  // The watchdog only fires when the device gave no answer this cycle, so a
  // late ack or err on the terminal cycle still wins.
  assign waiting     = request && !ack && !err;
  assign timeout_hit = TMO_EN && waiting && (tmo_cnt == TMO_LIMIT);
  assign pop         = request && (ack || err || timeout_hit);
  assign pop_err     = err || timeout_hit;

  // Entry storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {we_i, adr_i, dat_i, sel_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      tmo_cnt <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
    end else if (!cyc_i) begin
      // Abort: drop everything queued and any termination scheduled for the
      // next cycle. dat_o keeps its last value.
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      tmo_cnt <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end

      ack_o <= pop && !pop_err;
      err_o <= pop && pop_err;

      if (pop && !pop_err && !head.we) begin
        dat_o <= read_data;
      end

      if (pop || !request) begin
        tmo_cnt <= '0;
      end else if (TMO_EN) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wishbone_dev_pipelined.sv
// Testbench for wishbone_dev_pipelined with default parameters
// (8-bit address/data, DEPTH=4, TIMEOUT=16).
// Expected terminations are queued when the device response is driven and
// consumed when ack_o/err_o appears.

module tb_wishbone_dev_pipelined;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cyc_i;
  logic       stb_i;
  logic       we_i;
  logic [7:0] adr_i;
  logic [7:0] dat_i;
  logic [0:0] sel_i;
  logic [7:0] dat_o;
  logic       ack_o;
  logic       err_o;
  logic       stall_o;
  logic       request;
  logic       write_en;
  logic [7:0] address;
  logic [7:0] write_data;
  logic [0:0] byte_en;
  logic [7:0] read_data;
  logic       ack;
  logic       err;

  int total = 0;
  int bad   = 0;
  int n_ack = 0;
  int n_err = 0;

  typedef struct packed {
    logic       is_err;
    logic       chk;
    logic [7:0] data;
  } resp_t;

  resp_t exp_q[$];

  wishbone_dev_pipelined dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cyc_i      (cyc_i),
    .stb_i      (stb_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .sel_i      (sel_i),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .stall_o    (stall_o),
    .request    (request),
    .write_en   (write_en),
    .address    (address),
    .write_data (write_data),
    .byte_en    (byte_en),
    .read_data  (read_data),
    .ack        (ack),
    .err        (err)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard consumer: every termination must match the oldest expectation.
  always @(negedge clk_i) begin
    resp_t r;
    if (ack_o === 1'b1 || err_o === 1'b1) begin
      if (ack_o === 1'b1) n_ack++;
      if (err_o === 1'b1) n_err++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got ack_o=%b err_o=%b, expected no response", ack_o, err_o);
      end else begin
        r = exp_q.pop_front();
        if (ack_o === err_o || err_o !== r.is_err || (r.chk && dat_o !== r.data)) begin
          bad++;
          $display("FAIL resp_match: got ack_o=%b err_o=%b dat_o=%0h, expected err=%b dat=%0h (chk=%b)",
                   ack_o, err_o, dat_o, r.is_err, r.data, r.chk);
        end
      end
    end
  end

  task automatic test_reset();
    rst_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = 8'h77; dat_i = 8'h11; sel_i = 1'b1;
    tick(); tick();
    total++; if (request !== 1'b0) begin bad++; $display("FAIL reset_request: got %b expected 0", request); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    total++; if (ack_o !== 1'b0)   begin bad++; $display("FAIL reset_ack_o: got %b expected 0", ack_o); end
    total++; if (err_o !== 1'b0)   begin bad++; $display("FAIL reset_err_o: got %b expected 0", err_o); end
    total++; if (dat_o !== 8'h00)  begin bad++; $display("FAIL reset_dat_o: got %0h expected 0", dat_o); end
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h12; dat_i = 8'hA5; sel_i = 1'b1;
    tick();
    total++; if (request !== 1'b1)     begin bad++; $display("FAIL wr_request: got %b expected 1", request); end
    total++; if (address !== 8'h12)    begin bad++; $display("FAIL wr_address: got %0h expected 12", address); end
    total++; if (write_data !== 8'hA5) begin bad++; $display("FAIL wr_data: got %0h expected a5", write_data); end
    total++; if (write_en !== 1'b1)    begin bad++; $display("FAIL wr_we: got %b expected 1", write_en); end
    total++; if (byte_en !== 1'b1)     begin bad++; $display("FAIL wr_sel: got %b expected 1", byte_en); end
    stb_i = 1'b0; ack = 1'b1;
    exp_q.push_back(resp_t'({1'b0, 1'b0, 8'h00}));
    tick();
    ack = 1'b0;
    total++; if (ack_o !== 1'b1)   begin bad++; $display("FAIL wr_ack_latency: got %b expected 1", ack_o); end
    total++; if (request !== 1'b0) begin bad++; $display("FAIL wr_popped: got %b expected 0", request); end
    tick();
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse: got %b expected 0", ack_o); end
  endtask

  task automatic test_pipelined_reads();
    logic [7:0] aq[$];
    int acc = 0;
    int age = 0;
    int base = n_ack;
    bit sent;
    bit done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (n_ack - base >= 4) begin done = 1'b1; break; end
      cyc_i = 1'b1; stb_i = (acc < 4); we_i = 1'b0; adr_i = acc[7:0]; sel_i = 1'b1;
      sent = (acc < 4) && !stall_o;
      ack = 1'b0;
      if (request === 1'b1) begin
        age++;
        if (age == 3) begin
          total++;
          if (aq.size() == 0) begin
            bad++; $display("FAIL rd_order: got request with address %0h, expected none pending", address);
          end else begin
            if (address !== aq[0]) begin bad++; $display("FAIL rd_order: got address %0h expected %0h", address, aq[0]); end
            ack = 1'b1;
            read_data = 8'(8'h10 + aq[0]);
            exp_q.push_back(resp_t'({1'b0, 1'b1, read_data}));
            void'(aq.pop_front());
          end
          age = 0;
        end
      end else begin
        age = 0;
      end
      tick();
      if (sent) begin aq.push_back(acc[7:0]); acc++; end
    end
    stb_i = 1'b0; ack = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL rd_count: got %0d acks expected 4 (cycle budget)", n_ack - base); end
    total++; if (dat_o !== 8'h13) begin bad++; $display("FAIL rd_last_data: got %0h expected 13", dat_o); end
  endtask

  task automatic test_back_to_back();
    bit seen [7];
    for (int k = 0; k < 7; k++) begin
      cyc_i = 1'b1; stb_i = (k < 4); we_i = 1'b1; adr_i = 8'(8'h40 + k); dat_i = 8'(k); sel_i = 1'b1;
      ack = (request === 1'b1);
      if (ack) exp_q.push_back(resp_t'({1'b0, 1'b0, 8'h00}));
      tick();
      seen[k] = (ack_o === 1'b1);
    end
    stb_i = 1'b0; ack = 1'b0;
    for (int k = 0; k < 7; k++) begin
      total++;
      if (seen[k] !== ((k >= 1) && (k <= 4))) begin
        bad++; $display("FAIL b2b_ack_cycle%0d: got %b expected %b", k, seen[k], (k >= 1) && (k <= 4));
      end
    end
    total++; if (dat_o !== 8'h13) begin bad++; $display("FAIL b2b_dat_hold: got %0h expected 13", dat_o); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int pops = 0;
    int base = n_ack;
    bit sent;
    bit pop_now;
    for (int c = 0; c < 80; c++) begin
      if (acc == 6 && n_ack - base >= 6) break;
      cyc_i = 1'b1; stb_i = (acc < 6); we_i = 1'b1; adr_i = 8'(8'h60 + acc); dat_i = 8'(acc); sel_i = 1'b1;
      sent = (acc < 6) && !stall_o;
      pop_now = (request === 1'b1) && (c >= 10);
      ack = pop_now;
      if (pop_now) exp_q.push_back(resp_t'({1'b0, 1'b0, 8'h00}));
      tick();
      if (sent) begin
        acc++;
        if (acc >= 5) begin
          total++;
          if (pops < acc - 4) begin bad++; $display("FAIL bp_accept%0d: got accept after %0d pops expected >= %0d", acc, pops, acc - 4); end
        end
      end
      if (pop_now) pops++;
      if (acc == 4 && pops == 0) begin
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL bp_stall: got %b expected 1", stall_o); end
      end
    end
    stb_i = 1'b0; ack = 1'b0;
    total++; if (acc != 6) begin bad++; $display("FAIL bp_accepted: got %0d expected 6", acc); end
    total++; if (n_ack - base != 6) begin bad++; $display("FAIL bp_responses: got %0d expected 6", n_ack - base); end
  endtask

  task automatic test_error_timeout();
    int base_a = n_ack;
    int wait_cycles = 0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h20; sel_i = 1'b1;
    tick();
    adr_i = 8'h21;
    err = 1'b1;
    exp_q.push_back(resp_t'({1'b1, 1'b0, 8'h00}));
    exp_q.push_back(resp_t'({1'b1, 1'b0, 8'h00}));
    tick();
    stb_i = 1'b0; err = 1'b0;
    total++; if (err_o !== 1'b1)    begin bad++; $display("FAIL err_first: got %b expected 1", err_o); end
    total++; if (address !== 8'h21) begin bad++; $display("FAIL err_next_head: got %0h expected 21", address); end
    for (int j = 1; j <= 40; j++) begin
      tick();
      if (err_o === 1'b1) begin wait_cycles = j; break; end
    end
    total++; if (wait_cycles != 17) begin bad++; $display("FAIL tmo_latency: got %0d cycles expected 17", wait_cycles); end
    total++; if (request !== 1'b0)  begin bad++; $display("FAIL tmo_popped: got %b expected 0", request); end
    tick();
    total++; if (err_o !== 1'b0)    begin bad++; $display("FAIL tmo_pulse: got %b expected 0", err_o); end
    total++; if (n_ack != base_a)   begin bad++; $display("FAIL tmo_no_ack: got %0d acks expected 0", n_ack - base_a); end
  endtask

  task automatic test_abort();
    int base_a = n_ack;
    int base_e = n_err;
    for (int k = 0; k < 3; k++) begin
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'(8'h30 + k); dat_i = 8'hC0; sel_i = 1'b1;
      tick();
    end
    total++; if (request !== 1'b1) begin bad++; $display("FAIL abort_queued: got %b expected 1", request); end
    // The device acks on the very edge the cycle drops; that ack must vanish.
    cyc_i = 1'b0; stb_i = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (request !== 1'b0) begin bad++; $display("FAIL abort_request: got %b expected 0", request); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL abort_stall: got %b expected 0", stall_o); end
    total++; if (ack_o !== 1'b0)   begin bad++; $display("FAIL abort_ack_o: got %b expected 0", ack_o); end
    total++; if (err_o !== 1'b0)   begin bad++; $display("FAIL abort_err_o: got %b expected 0", err_o); end
    tick(); tick(); tick();
    total++;
    if (n_ack != base_a || n_err != base_e) begin
      bad++; $display("FAIL abort_silence: got %0d acks %0d errs expected 0 0", n_ack - base_a, n_err - base_e);
    end
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h44;
    tick();
    stb_i = 1'b0;
    total++; if (address !== 8'h44) begin bad++; $display("FAIL abort_new_head: got %0h expected 44", address); end
    total++; if (write_en !== 1'b0) begin bad++; $display("FAIL abort_new_we: got %b expected 0", write_en); end
    ack = 1'b1; read_data = 8'h5A;
    exp_q.push_back(resp_t'({1'b0, 1'b1, 8'h5A}));
    tick();
    ack = 1'b0;
    total++; if (ack_o !== 1'b1)  begin bad++; $display("FAIL abort_new_ack: got %b expected 1", ack_o); end
    total++; if (dat_o !== 8'h5A) begin bad++; $display("FAIL abort_new_data: got %0h expected 5a", dat_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    int base_a = n_ack;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 8'h50; dat_i = 8'h01; sel_i = 1'b1;
    tick();
    adr_i = 8'h51;
    tick();
    stb_i = 1'b0; rst_i = 1'b1; ack = 1'b1;
    tick();
    rst_i = 1'b0; ack = 1'b0; cyc_i = 1'b0;
    total++; if (ack_o !== 1'b0)   begin bad++; $display("FAIL rstmid_ack_o: got %b expected 0", ack_o); end
    total++; if (err_o !== 1'b0)   begin bad++; $display("FAIL rstmid_err_o: got %b expected 0", err_o); end
    total++; if (dat_o !== 8'h00)  begin bad++; $display("FAIL rstmid_dat_o: got %0h expected 0", dat_o); end
    total++; if (request !== 1'b0) begin bad++; $display("FAIL rstmid_request: got %b expected 0", request); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b expected 0", stall_o); end
    tick(); tick();
    total++; if (n_ack != base_a) begin bad++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", n_ack - base_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0; read_data = '0; ack = 1'b0; err = 1'b0;
    test_reset();
    test_single_write();
    test_pipelined_reads();
    test_back_to_back();
    test_backpressure();
    test_error_timeout();
    test_abort();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d outstanding expectations expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wishbone_dev_pipelined.md
Name: wishbone_dev_pipelined

Overview:
Wishbone B4 pipelined-mode device adapter. It turns bus cycles into a simple in-order request/ack interface for a local device. It is parametrised in address width, data width and command-queue depth, and adds byte selects, error responses and a watchdog timeout. It sits between a pipelined Wishbone controller and register or memory devices, so several requests can be in flight at once.

Parameters:
ADR_WIDTH, 8, address width.
DAT_WIDTH, 8, data width; must be a multiple of 8.
SEL_WIDTH, DAT_WIDTH/8, byte-select width.
DEPTH, 4, command FIFO entries; must be a power of two and at least 2.
TIMEOUT, 16, cycles the head request may wait for ack/err before being error-terminated; 0 disables the timeout.

Ports:
clk_i  in  1  clock, all logic on the rising edge.
rst_i  in  1  synchronous, active-high reset.
cyc_i  in  1  bus cycle active.
stb_i  in  1  strobe; one request per cycle when not stalled.
we_i  in  1  write enable.
adr_i  in  ADR_WIDTH  address.
dat_i  in  DAT_WIDTH  write data.
sel_i  in  SEL_WIDTH  byte selects.
dat_o  out  DAT_WIDTH  read data, valid with ack_o.
ack_o  out  1  normal termination, one cycle per request.
err_o  out  1  error termination, one cycle per request.
stall_o  out  1  request not accepted this cycle.
request  out  1  FIFO head valid; device must act on it.
write_en  out  1  head is a write.
address  out  ADR_WIDTH  head address.
write_data  out  DAT_WIDTH  head write data.
byte_en  out  SEL_WIDTH  head byte selects.
read_data  in  DAT_WIDTH  device read data, sampled with ack.
ack  in  1  device completes the head request this cycle.
err  in  1  device fails the head request this cycle.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: FIFO empty, timeout counter 0, ack_o=0, err_o=0, dat_o=0. Consequently stall_o=0 and request=0.
- Accept: a request is accepted on an edge where cyc_i && stb_i && !stall_o. The accepted {we_i, adr_i, dat_i, sel_i} is pushed into the FIFO.
- stall_o: combinational, equals FIFO full. No push-while-full, even if a pop occurs the same cycle.
- Device side: request = FIFO non-empty. write_en, address, write_data and byte_en are driven combinationally from the head entry and held stable until the head is popped.
- Completion: on an edge with request && (ack || err), the head is popped.
  - Next cycle, exactly one of ack_o or err_o is high for one cycle. err has priority over ack.
  - dat_o is loaded with read_data on an ack pop of a read; otherwise dat_o holds its value.
- Back-to-back completions: ack held high completes one entry per cycle. Sustained throughput is 1 request per cycle.
- Minimum latency: request accepted at edge N, request visible after edge N, device acks at edge N+1, ack_o high in the cycle after edge N+1.
- Timeout:
  - The counter is cleared on every pop and whenever the FIFO is empty, and increments each cycle request is high without ack or err.
  - When it reaches TIMEOUT, the head is popped at that edge and err_o pulses next cycle. The device sees request drop or advance.
  - Counter width is clog2(TIMEOUT+1).
- Ordering: responses are strictly in acceptance order; number of responses equals number of accepted requests while cyc_i stays high.
- Abort: cyc_i low at an edge flushes the FIFO and clears the timeout counter. Any ack_o/err_o for a response not yet issued is suppressed, and an ack_o/err_o already scheduled for the next cycle is cleared. The device must tolerate request dropping mid-operation.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Reset during an operation: it behaves as reset in every respect. The FIFO is flushed and pending responses are lost.

Test Plan:
- Single write: adr=0x12, dat=0xA5, sel=1, device ack at first request cycle -> address=0x12, write_data=0xA5, write_en=1; ack_o single pulse 2 cycles after stb accepted.
- Pipelined reads: 4 reads, adr 0..3, device acks 3 cycles after each request with read_data=0x10+adr -> ack_o pulses in order, dat_o=0x10,0x11,0x12,0x13.
- Backpressure: DEPTH=4, device holds ack low, 6 strobes -> stall_o high after the 4th accept; the 5th and 6th are accepted only after pops; 6 responses in total.
- Error and timeout: device asserts err on 1st request and never responds to the 2nd, TIMEOUT=16 -> err_o pulse after the 1st; err_o exactly 17 cycles after the 2nd becomes head; no ack_o.
- Abort: 3 requests queued, cyc_i dropped before any ack -> request low next cycle, no ack_o/err_o, stall_o=0, new cycle starts clean.
- Reset mid-stream: rst_i high with 2 pending -> all outputs at reset values the following cycle.
